// File: rtl/spi_pkg.sv
// Shared definitions for the SPI control unit and the RAM arbiter:
// port IDs, SPI opcodes and the registered memory command bundle.
package spi_pkg;

  localparam logic PORT_SPI  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  // Command bundle is sized for the register RAM; the arbiter casts to its port widths.
  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 8;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester grant logic: a single eligible port always wins; a tie goes
// to SPI in priority mode, otherwise to the port that was not granted last.
module rr_arb2
  import spi_pkg::*;
(
  input  logic i_elig_spi,
  input  logic i_elig_host,
  input  logic i_last_grant,
  input  logic i_spi_priority,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  always_comb begin
    o_gnt_valid = i_elig_spi | i_elig_host;
    o_gnt_id    = PORT_SPI;
    if (i_elig_spi && i_elig_host) begin
      o_gnt_id = i_spi_priority ? PORT_SPI : ~i_last_grant;
    end else if (i_elig_host) begin
      o_gnt_id = PORT_HOST;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares the single-port synchronous-read register RAM between the SPI control
// unit and the host bus; one access per cycle, read data routed back by tag.
module spi_mem_arbiter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_SIZE = 8,
  parameter int SPI_PRIORITY = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_spi_req,
  input  logic                    i_spi_we,
  input  logic [ADDRESS_SIZE-1:0] i_spi_addr,
  input  logic [DATA_WIDTH-1:0]   i_spi_wdata,
  output logic                    o_spi_ack,
  output logic                    o_spi_rvalid,
  output logic [DATA_WIDTH-1:0]   o_spi_rdata,
  input  logic                    i_host_req,
  input  logic                    i_host_we,
  input  logic [ADDRESS_SIZE-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0]   i_host_wdata,
  output logic                    o_host_ack,
  output logic                    o_host_rvalid,
  output logic [DATA_WIDTH-1:0]   o_host_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [ADDRESS_SIZE-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic [15:0]             o_conflict_cnt
);

  // Handshake: a port is eligible while req=1 and its ack=0; ack is a one-cycle
  // pulse meaning the command was issued, so a req still high during the ack
  // cycle is ignored and the requester may present its next command right after.
  logic     spi_elig, host_elig;
  logic     gnt_valid, gnt_id;
  logic     last_grant;
  mem_cmd_t gnt_cmd, cmd_q;
  logic     t1_valid, t1_port, t2_valid, t2_port;

  assign spi_elig  = i_spi_req & ~o_spi_ack;
  assign host_elig = i_host_req & ~o_host_ack;

  rr_arb2 u_arb (
    .i_elig_spi     (spi_elig),
    .i_elig_host    (host_elig),
    .i_last_grant   (last_grant),
    .i_spi_priority (SPI_PRIORITY != 0),
    .o_gnt_valid    (gnt_valid),
    .o_gnt_id       (gnt_id)
  );

  always_comb begin
    gnt_cmd.we    = i_spi_we;
    gnt_cmd.addr  = CMD_ADDR_W'(i_spi_addr);
    gnt_cmd.wdata = CMD_DATA_W'(i_spi_wdata);
    if (gnt_id == PORT_HOST) begin
      gnt_cmd.we    = i_host_we;
      gnt_cmd.addr  = CMD_ADDR_W'(i_host_addr);
      gnt_cmd.wdata = CMD_DATA_W'(i_host_wdata);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_en       <= 1'b0;
      o_spi_ack      <= 1'b0;
      o_host_ack     <= 1'b0;
      cmd_q          <= '0;
      last_grant     <= PORT_HOST;
      t1_valid       <= 1'b0;
      t1_port        <= PORT_SPI;
      t2_valid       <= 1'b0;
      t2_port        <= PORT_SPI;
      o_spi_rvalid   <= 1'b0;
      o_host_rvalid  <= 1'b0;
      o_spi_rdata    <= '0;
      o_host_rdata   <= '0;
      o_conflict_cnt <= '0;
    end else begin
      o_mem_en   <= gnt_valid;
      o_spi_ack  <= gnt_valid && (gnt_id == PORT_SPI);
      o_host_ack <= gnt_valid && (gnt_id == PORT_HOST);
      if (gnt_valid) begin
        cmd_q      <= gnt_cmd;
        last_grant <= gnt_id;
      end
      // Tags follow reads through the RAM's one-cycle read latency.
      t1_valid      <= gnt_valid && !gnt_cmd.we;
      t1_port       <= gnt_id;
      t2_valid      <= t1_valid;
      t2_port       <= t1_port;
      o_spi_rvalid  <= t2_valid && (t2_port == PORT_SPI);
      o_host_rvalid <= t2_valid && (t2_port == PORT_HOST);
      if (t2_valid && (t2_port == PORT_SPI)) o_spi_rdata <= i_mem_rdata;
      if (t2_valid && (t2_port == PORT_HOST)) o_host_rdata <= i_mem_rdata;
      if (spi_elig && host_elig && (o_conflict_cnt != 16'hFFFF)) begin
        o_conflict_cnt <= o_conflict_cnt + 16'd1;
      end
    end
  end

  assign o_mem_we    = cmd_q.we;
  assign o_mem_addr  = ADDRESS_SIZE'(cmd_q.addr);
  assign o_mem_wdata = DATA_WIDTH'(cmd_q.wdata);

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: a round-robin instance with a RAM model
// and a fixed-priority instance; read returns are matched against expected queues.
module tb_spi_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance
  logic       spi_req, spi_we, spi_ack, spi_rvalid;
  logic [7:0] spi_addr, spi_wdata, spi_rdata;
  logic       host_req, host_we, host_ack, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  // Fixed-priority instance
  logic       p_spi_req, p_spi_we, p_spi_ack, p_spi_rvalid;
  logic [7:0] p_spi_addr, p_spi_wdata, p_spi_rdata;
  logic       p_host_req, p_host_we, p_host_ack, p_host_rvalid;
  logic [7:0] p_host_addr, p_host_wdata, p_host_rdata;
  logic       p_mem_en, p_mem_we;
  logic [7:0] p_mem_addr, p_mem_wdata, p_mem_rdata;
  logic [15:0] p_conflict_cnt;

  assign p_mem_rdata = 8'h00;

  spi_mem_arbiter #(.DATA_WIDTH(8), .ADDRESS_SIZE(8), .SPI_PRIORITY(0)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_spi_req(spi_req), .i_spi_we(spi_we), .i_spi_addr(spi_addr), .i_spi_wdata(spi_wdata),
    .o_spi_ack(spi_ack), .o_spi_rvalid(spi_rvalid), .o_spi_rdata(spi_rdata),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_ack(host_ack), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_conflict_cnt(conflict_cnt)
  );

  spi_mem_arbiter #(.DATA_WIDTH(8), .ADDRESS_SIZE(8), .SPI_PRIORITY(1)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_spi_req(p_spi_req), .i_spi_we(p_spi_we), .i_spi_addr(p_spi_addr), .i_spi_wdata(p_spi_wdata),
    .o_spi_ack(p_spi_ack), .o_spi_rvalid(p_spi_rvalid), .o_spi_rdata(p_spi_rdata),
    .i_host_req(p_host_req), .i_host_we(p_host_we), .i_host_addr(p_host_addr), .i_host_wdata(p_host_wdata),
    .o_host_ack(p_host_ack), .o_host_rvalid(p_host_rvalid), .o_host_rdata(p_host_rdata),
    .o_mem_en(p_mem_en), .o_mem_we(p_mem_we), .o_mem_addr(p_mem_addr), .o_mem_wdata(p_mem_wdata),
    .i_mem_rdata(p_mem_rdata), .o_conflict_cnt(p_conflict_cnt)
  );

  // Synchronous-read RAM model for the round-robin instance
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  logic [53:0] rr_outs;
  assign rr_outs = {mem_en, mem_we, spi_ack, host_ack, spi_rvalid, host_rvalid,
                    mem_addr, mem_wdata, spi_rdata, host_rdata, conflict_cnt};

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] spi_exp_q[$];
  logic [7:0] host_exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: step to the falling edge, then score any read return.
  task automatic tick();
    @(negedge clk);
    if (spi_rvalid) begin
      if (spi_exp_q.size() == 0) check("spi_unexpected_rvalid", spi_rvalid, 0);
      else check("spi_rdata", spi_rdata, spi_exp_q.pop_front());
    end
    if (host_rvalid) begin
      if (host_exp_q.size() == 0) check("host_unexpected_rvalid", host_rvalid, 0);
      else check("host_rdata", host_rdata, host_exp_q.pop_front());
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    spi_req = 1'b0; host_req = 1'b0; p_spi_req = 1'b0; p_host_req = 1'b0;
    tick();
    tick();
    check("reset_outputs", rr_outs, 0);
    rst = 1'b0;
  endtask

  logic seen;

  initial begin
    rst = 1'b1;
    spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    p_spi_req = 0; p_spi_we = 0; p_spi_addr = 0; p_spi_wdata = 0;
    p_host_req = 0; p_host_we = 0; p_host_addr = 0; p_host_wdata = 0;
    apply_reset();

    // Idle: RAM untouched
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= mem_en;
    end
    check("idle_mem_en", seen, 0);
    check("idle_conflict", conflict_cnt, 0);

    // SPI write A5 -> 10, then read back
    spi_req = 1; spi_we = 1; spi_addr = 8'h10; spi_wdata = 8'hA5;
    tick();
    check("spi_wr_issue", {spi_ack, host_ack, mem_en, mem_we, mem_addr, mem_wdata}, {4'b1011, 8'h10, 8'hA5});
    spi_req = 0;
    tick();
    check("spi_wr_idle", {spi_ack, mem_en}, 0);
    spi_req = 1; spi_we = 0; spi_addr = 8'h10;
    spi_exp_q.push_back(8'hA5);
    tick();
    check("spi_rd_issue", {spi_ack, mem_en, mem_we, mem_addr}, {3'b110, 8'h10});
    spi_req = 0;
    tick();
    check("spi_rd_t2_rvalid", spi_rvalid, 0);
    tick();
    check("spi_rd_t3_rvalid", spi_rvalid, 1);
    check("spi_rd_drained", spi_exp_q.size(), 0);

    // Host write 5A -> 11
    host_req = 1; host_we = 1; host_addr = 8'h11; host_wdata = 8'h5A;
    tick();
    check("host_wr_issue", {spi_ack, host_ack, mem_en, mem_we, mem_addr, mem_wdata}, {4'b0111, 8'h11, 8'h5A});
    host_req = 0;
    tick();

    // Round-robin tie from reset: S, H, S, H
    apply_reset();
    spi_exp_q.push_back(8'hA5);  spi_exp_q.push_back(8'hA5);
    host_exp_q.push_back(8'h5A); host_exp_q.push_back(8'h5A);
    spi_req = 1;  spi_we = 0;  spi_addr = 8'h10;
    host_req = 1; host_we = 0; host_addr = 8'h11;
    tick();
    check("tie_grant1", {spi_ack, host_ack}, 2'b10);
    check("tie_cnt1", conflict_cnt, 1);
    tick();
    check("tie_grant2", {spi_ack, host_ack}, 2'b01);
    tick();
    check("tie_grant3", {spi_ack, host_ack}, 2'b10);
    spi_req = 0;
    tick();
    check("tie_grant4", {spi_ack, host_ack}, 2'b01);
    check("tie_cnt_final", conflict_cnt, 1);
    host_req = 0;
    repeat (3) tick();
    check("tie_drained", spi_exp_q.size() + host_exp_q.size(), 0);

    // Ordering: last grant SPI, host write and SPI read to the same address
    spi_req = 1; spi_we = 1; spi_addr = 8'h20; spi_wdata = 8'h11;
    tick();
    check("ord_pre_wr", {spi_ack, mem_we, mem_addr}, {2'b11, 8'h20});
    spi_req = 0;
    tick();
    spi_req = 1;  spi_we = 0;  spi_addr = 8'h20;
    host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h3C;
    spi_exp_q.push_back(8'h3C);
    tick();
    check("ord_host_first", {spi_ack, host_ack, mem_we, mem_wdata}, {3'b011, 8'h3C});
    check("ord_cnt", conflict_cnt, 2);
    host_req = 0;
    tick();
    check("ord_spi_second", {spi_ack, host_ack, mem_we}, 3'b100);
    spi_req = 0;
    repeat (2) tick();
    check("ord_drained", spi_exp_q.size(), 0);

    // Reset in T2 of an SPI read drops the return
    spi_req = 1; spi_we = 0; spi_addr = 8'h10;
    tick();
    check("rst_rd_issue", spi_ack, 1);
    spi_req = 0;
    tick();
    rst = 1;
    tick();
    check("rst_mid_outputs", rr_outs, 0);
    rst = 0;
    seen = spi_rvalid;
    repeat (3) begin
      tick();
      seen |= spi_rvalid;
    end
    check("rst_no_rvalid", seen, 0);
    spi_req = 1; spi_we = 0; spi_addr = 8'h11;
    spi_exp_q.push_back(8'h5A);
    tick();
    check("post_rst_issue", {spi_ack, mem_addr}, {1'b1, 8'h11});
    spi_req = 0;
    repeat (2) tick();
    check("post_rst_drained", spi_exp_q.size(), 0);

    // Fixed priority: SPI wins the tie even though it was granted last
    p_spi_req = 1; p_spi_we = 1; p_spi_addr = 8'h30; p_spi_wdata = 8'h01;
    tick();
    check("fp_pre_wr", p_spi_ack, 1);
    p_spi_req = 0;
    tick();
    p_spi_req = 1;  p_spi_we = 1;  p_spi_addr = 8'h40; p_spi_wdata = 8'h00;
    p_host_req = 1; p_host_we = 1; p_host_addr = 8'h50; p_host_wdata = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fp_grant", {p_spi_ack, p_host_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("fp_addr", p_mem_addr, (k % 2 == 0) ? (8'h40 + k / 2) : 8'h50);
      if (k % 2 == 0) begin
        p_spi_addr  = p_spi_addr + 8'd1;
        p_spi_wdata = p_spi_wdata + 8'd1;
      end
    end
    p_spi_req = 0; p_host_req = 0;
    tick();
    check("fp_cnt", p_conflict_cnt, 1);
    check("fp_idle", p_mem_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
